// File: rtl/bcd_counter_mod.sv
// -----------------------------------------------------------------------------
// bcd_counter_mod
//   N-digit BCD modulo counter with an on-chip prescaler, up/down counting,
//   synchronous clear/load and registered per-digit 7-segment outputs.
//   Arithmetic is done digit by digit with ripple carry/borrow, so there is no
//   binary-to-BCD conversion on the count path.
//
// Parameters
//   DIGITS          number of BCD digits (1..6)
//   MODULUS         count range 0..MODULUS-1 (2..10**DIGITS)
//   CLK_DIV         clk_sys cycles per count step (>= 1)
//   SEG_ACTIVE_LOW  1: segment bit 0 = lit, 0: segment bit 1 = lit
//
// Ports
//   clk_sys_i     system clock, posedge
//   clr_n_i       async active-low reset
//   clr_i         sync clear (highest sync priority)
//   pause_i       hold count: no steps, no rco (prescaler keeps running)
//   up_dn_i       1 = up, 0 = down
//   load_i        sync load of load_val_i (rejected if not valid BCD < MODULUS)
//   load_val_i    BCD value, digit 0 in [3:0]
//   tick_o        prescaler strobe, high while div_cnt == CLK_DIV-1
//   rco_o         combinational carry/borrow, high in the cycle of a wrap step
//   load_err_o    1-cycle pulse after a rejected load
//   sign_pause_o  registered pause_i
//   bcd_o         current count, digit 0 = ones
//   seg_o         gfedcba per digit, digit 0 in [6:0], lags bcd_o by 1 cycle
//
// Build option
//   BCD_COUNTER_BLANK_EN  when defined, leading-zero digits (except digit 0)
//                         are blanked on seg_o; bcd_o is unaffected.
// -----------------------------------------------------------------------------
module bcd_counter_mod #(
    parameter int DIGITS         = 2,
    parameter int MODULUS        = 100,
    parameter int CLK_DIV        = 50000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk_sys_i,
    input  logic                  clr_n_i,
    input  logic                  clr_i,
    input  logic                  pause_i,
    input  logic                  up_dn_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic                  tick_o,
    output logic                  rco_o,
    output logic                  load_err_o,
    output logic                  sign_pause_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [7*DIGITS-1:0]   seg_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (DIGITS < 1 || DIGITS > 6 || MODULUS < 2 || MODULUS > 10**DIGITS || CLK_DIV < 1) begin : g_bad_param
        $error("bcd_counter_mod: illegal parameters DIGITS=%0d MODULUS=%0d CLK_DIV=%0d",
               DIGITS, MODULUS, CLK_DIV);
    end

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        int r;
        logic [4*DIGITS-1:0] res;
        r   = v;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    // Raw active-low gfedcba pattern; non-decimal codes show nothing.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? p : ~p;
    endfunction

    // Terminal value for up-counting, also the down-wrap target.
    localparam logic [4*DIGITS-1:0] TERM_UP  = to_bcd(MODULUS - 1);
    localparam logic [6:0]          SEG_ZERO = (SEG_ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;
    localparam logic [6:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                load_err_q, load_err_d;
    logic                sign_pause_q;

    logic [4*DIGITS-1:0] inc_val, dec_val;
    logic                terminal, step, load_ok;

    assign tick_o   = (div_q == DIV_LAST);
    assign terminal = up_dn_i ? (count_q == TERM_UP) : (count_q == '0);
    assign step     = tick_o & ~pause_i & ~clr_i & ~load_i;
    assign rco_o    = step & terminal;

    // Ripple increment/decrement, one digit at a time.
    always_comb begin
        logic       cy, bw;
        logic [3:0] dg;
        inc_val = count_q;
        dec_val = count_q;
        cy      = 1'b1;
        bw      = 1'b1;
        dg      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dg = count_q[4*i +: 4];
            if (cy) begin
                if (dg == 4'd9) inc_val[4*i +: 4] = 4'd0;
                else begin
                    inc_val[4*i +: 4] = dg + 4'd1;
                    cy = 1'b0;
                end
            end
            if (bw) begin
                if (dg == 4'd0) dec_val[4*i +: 4] = 4'd9;
                else begin
                    dec_val[4*i +: 4] = dg - 4'd1;
                    bw = 1'b0;
                end
            end
        end
    end

    // With every digit <= 9, BCD order equals numeric order, so a plain
    // unsigned compare against the terminal value checks the range.
    always_comb begin
        load_ok = (load_val_i <= TERM_UP);
        for (int i = 0; i < DIGITS; i++)
            if (load_val_i[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end

    always_comb begin
        count_d    = count_q;
        div_d      = tick_o ? '0 : div_q + DIV_W'(1);
        load_err_d = 1'b0;
        if (clr_i) begin
            count_d = '0;
            div_d   = '0;
        end else if (load_i) begin
            if (load_ok) begin
                count_d = load_val_i;
                div_d   = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step) begin
            if (terminal) count_d = up_dn_i ? '0 : TERM_UP;
            else          count_d = up_dn_i ? inc_val : dec_val;
        end
    end

    always_comb begin
`ifdef BCD_COUNTER_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        seg_d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seg_d[7*i +: 7] = seg7(count_q[4*i +: 4]);
`ifdef BCD_COUNTER_BLANK_EN
            // lead stays set while every digit from the top down to i is zero
            lead = lead & (count_q[4*i +: 4] == 4'd0);
            if (lead && i != 0) seg_d[7*i +: 7] = SEG_OFF;
`endif
        end
    end

    always_ff @(posedge clk_sys_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            div_q        <= '0;
            count_q      <= '0;
            load_err_q   <= 1'b0;
            sign_pause_q <= 1'b0;
            seg_q        <= {DIGITS{SEG_ZERO}};
        end else begin
            div_q        <= div_d;
            count_q      <= count_d;
            load_err_q   <= load_err_d;
            sign_pause_q <= pause_i;
            seg_q        <= seg_d;
        end
    end

    assign load_err_o   = load_err_q;
    assign sign_pause_o = sign_pause_q;
    assign bcd_o        = count_q;
    assign seg_o        = seg_q;

endmodule

// File: tb/tb_bcd_counter_mod.sv
module tb_bcd_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DIGITS=2, MODULUS=100, CLK_DIV=4
    logic a_rst_n, a_clr, a_pause, a_up, a_load;
    logic [7:0]  a_lv, a_bcd;
    logic        a_tick, a_rco, a_lerr, a_sp;
    logic [13:0] a_seg;

    // Instance B: DIGITS=2, MODULUS=60, CLK_DIV=1
    logic b_rst_n, b_clr, b_pause, b_up, b_load;
    logic [7:0]  b_lv, b_bcd;
    logic        b_tick, b_rco, b_lerr, b_sp;
    logic [13:0] b_seg;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    bcd_counter_mod #(.DIGITS(2), .MODULUS(100), .CLK_DIV(4), .SEG_ACTIVE_LOW(1)) u_a (
        .clk_sys_i(clk), .clr_n_i(a_rst_n), .clr_i(a_clr), .pause_i(a_pause), .up_dn_i(a_up),
        .load_i(a_load), .load_val_i(a_lv), .tick_o(a_tick), .rco_o(a_rco), .load_err_o(a_lerr),
        .sign_pause_o(a_sp), .bcd_o(a_bcd), .seg_o(a_seg));

    bcd_counter_mod #(.DIGITS(2), .MODULUS(60), .CLK_DIV(1), .SEG_ACTIVE_LOW(1)) u_b (
        .clk_sys_i(clk), .clr_n_i(b_rst_n), .clr_i(b_clr), .pause_i(b_pause), .up_dn_i(b_up),
        .load_i(b_load), .load_val_i(b_lv), .tick_o(b_tick), .rco_o(b_rco), .load_err_o(b_lerr),
        .sign_pause_o(b_sp), .bcd_o(b_bcd), .seg_o(b_seg));

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] exp_seg(input int v);
        logic [6:0] hi, lo;
        hi = SEG_TBL[v / 10];
        lo = SEG_TBL[v % 10];
`ifdef BCD_COUNTER_BLANK_EN
        if (v / 10 == 0) hi = 7'b1111111;
`endif
        return {hi, lo};
    endfunction

    task automatic test_reset;
        a_rst_n = 0; a_clr = 0; a_pause = 0; a_up = 1; a_load = 0; a_lv = 0;
        b_rst_n = 0; b_clr = 0; b_pause = 0; b_up = 0; b_load = 0; b_lv = 0;
        repeat (3) @(negedge clk);
        checks++; if (a_bcd !== 8'h00) begin failures++; $display("FAIL reset_bcd got=%h exp=00", a_bcd); end
        checks++; if ({a_tick, a_rco, a_lerr, a_sp} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {a_tick, a_rco, a_lerr, a_sp}); end
        checks++; if (a_seg !== {7'b1000000, 7'b1000000}) begin failures++; $display("FAIL reset_seg got=%b exp=10000001000000", a_seg); end
    endtask

    // Test 1: count up 00..99..00 with CLK_DIV=4
    task automatic test_count_up;
        int exp_v, exp_div, prev, rco_cnt, tick_cnt;
        exp_v = 0; exp_div = 0; prev = 0; rco_cnt = 0; tick_cnt = 0;
        a_rst_n = 1;
        repeat (400) begin
            @(posedge clk);
            prev = exp_v;
            if (exp_div == 3) begin exp_v = (exp_v + 1) % 100; exp_div = 0; end
            else exp_div++;
            @(negedge clk);
            checks++; if (a_bcd !== to_bcd2(exp_v)) begin failures++; $display("FAIL up_bcd got=%h exp=%h", a_bcd, to_bcd2(exp_v)); end
            checks++; if (a_tick !== (exp_div == 3)) begin failures++; $display("FAIL up_tick got=%b exp=%b", a_tick, exp_div == 3); end
            checks++; if (a_rco !== (exp_div == 3 && exp_v == 99)) begin failures++; $display("FAIL up_rco got=%b at %0d", a_rco, exp_v); end
            checks++; if (a_seg !== exp_seg(prev)) begin failures++; $display("FAIL up_seg got=%b exp=%b", a_seg, exp_seg(prev)); end
            rco_cnt += int'(a_rco);
            tick_cnt += int'(a_tick);
        end
        checks++; if (rco_cnt != 1) begin failures++; $display("FAIL up_rco_count got=%0d exp=1", rco_cnt); end
        checks++; if (tick_cnt != 100) begin failures++; $display("FAIL up_tick_count got=%0d exp=100", tick_cnt); end
        checks++; if (a_bcd !== 8'h00) begin failures++; $display("FAIL up_final got=%h exp=00", a_bcd); end
    endtask

    // Test 2: MODULUS=60, CLK_DIV=1, down from 00 (covers 50->49, 10->09)
    task automatic test_count_down;
        int exp_v;
        b_rst_n = 1;
        #1;
        checks++; if ({b_bcd, b_tick, b_rco} !== {8'h00, 2'b11}) begin failures++; $display("FAIL down_start got=%h %b%b exp=00 11", b_bcd, b_tick, b_rco); end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            exp_v = (60 - k) % 60;
            checks++; if (b_bcd !== to_bcd2(exp_v)) begin failures++; $display("FAIL down_bcd got=%h exp=%h", b_bcd, to_bcd2(exp_v)); end
            checks++; if (b_rco !== (exp_v == 0)) begin failures++; $display("FAIL down_rco got=%b at %0d", b_rco, exp_v); end
        end
    endtask

    // Test 3: loads, bad digit, out-of-range value
    task automatic test_load;
        logic [7:0] held;
        @(negedge clk);
        a_pause = 1; a_load = 1; a_lv = 8'h42;
        @(negedge clk);
        checks++; if ({a_bcd, a_lerr} !== {8'h42, 1'b0}) begin failures++; $display("FAIL load42 got=%h err=%b exp=42 err=0", a_bcd, a_lerr); end
        a_lv = 8'h3A;
        @(negedge clk);
        checks++; if ({a_bcd, a_lerr} !== {8'h42, 1'b1}) begin failures++; $display("FAIL load3A got=%h err=%b exp=42 err=1", a_bcd, a_lerr); end
        a_load = 0;
        @(negedge clk);
        checks++; if ({a_bcd, a_lerr} !== {8'h42, 1'b0}) begin failures++; $display("FAIL load_err_pulse got=%h err=%b exp=42 err=0", a_bcd, a_lerr); end
        a_pause = 0;

        b_pause = 1; b_load = 1; b_lv = 8'h75; held = b_bcd;
        @(negedge clk);
        checks++; if ({b_bcd, b_lerr} !== {held, 1'b1}) begin failures++; $display("FAIL load75_m60 got=%h err=%b exp=%h err=1", b_bcd, b_lerr, held); end
        b_lv = 8'h59;
        @(negedge clk);
        checks++; if ({b_bcd, b_lerr} !== {8'h59, 1'b0}) begin failures++; $display("FAIL load59_m60 got=%h err=%b exp=59 err=0", b_bcd, b_lerr); end
        b_lv = 8'h60;
        @(negedge clk);
        checks++; if ({b_bcd, b_lerr} !== {8'h59, 1'b1}) begin failures++; $display("FAIL load60_m60 got=%h err=%b exp=59 err=1", b_bcd, b_lerr); end
        b_load = 0;
    endtask

    // Test 4: clr on a tick at 99, load on a tick, then a direction change
    task automatic test_simultaneous;
        a_load = 1; a_lv = 8'h99;
        @(negedge clk);
        a_load = 0;
        checks++; if ({a_bcd, a_tick} !== {8'h99, 1'b0}) begin failures++; $display("FAIL sim_load99 got=%h tick=%b", a_bcd, a_tick); end
        repeat (3) @(negedge clk);
        checks++; if ({a_tick, a_rco} !== 2'b11) begin failures++; $display("FAIL sim_rco99 got=%b%b exp=11", a_tick, a_rco); end
        a_clr = 1;
        #1;
        checks++; if (a_rco !== 1'b0) begin failures++; $display("FAIL sim_clr_rco got=%b exp=0", a_rco); end
        @(negedge clk);
        a_clr = 0;
        checks++; if ({a_bcd, a_tick} !== {8'h00, 1'b0}) begin failures++; $display("FAIL sim_clr got=%h tick=%b exp=00 0", a_bcd, a_tick); end
        repeat (3) @(negedge clk);
        checks++; if (a_tick !== 1'b1) begin failures++; $display("FAIL sim_clr_div got=%b exp=1", a_tick); end
        a_load = 1; a_lv = 8'h25;
        @(negedge clk);
        a_load = 0;
        checks++; if ({a_bcd, a_tick} !== {8'h25, 1'b0}) begin failures++; $display("FAIL sim_load_tick got=%h tick=%b exp=25 0", a_bcd, a_tick); end
        repeat (2) @(negedge clk);
        checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL sim_div_restart got=%b exp=0", a_tick); end
        @(negedge clk);
        checks++; if ({a_bcd, a_tick} !== {8'h25, 1'b1}) begin failures++; $display("FAIL sim_div_tick got=%h tick=%b exp=25 1", a_bcd, a_tick); end
        @(negedge clk);
        checks++; if (a_bcd !== 8'h26) begin failures++; $display("FAIL sim_step got=%h exp=26", a_bcd); end
        a_up = 0;
        repeat (3) @(negedge clk);
        checks++; if (a_bcd !== 8'h26) begin failures++; $display("FAIL dir_hold got=%h exp=26", a_bcd); end
        @(negedge clk);
        checks++; if (a_bcd !== 8'h25) begin failures++; $display("FAIL dir_down got=%h exp=25", a_bcd); end
        a_up = 1;
    endtask

    // Test 5: pause for 20 ticks
    task automatic test_pause;
        int tick_cnt, bad;
        tick_cnt = 0; bad = 0;
        a_pause = 1;
        #1;
        checks++; if (a_sp !== 1'b0) begin failures++; $display("FAIL pause_sp_early got=%b exp=0", a_sp); end
        @(negedge clk);
        checks++; if (a_sp !== 1'b1) begin failures++; $display("FAIL pause_sp got=%b exp=1", a_sp); end
        tick_cnt += int'(a_tick);
        repeat (79) begin
            @(negedge clk);
            if (a_bcd !== 8'h25 || a_rco !== 1'b0) bad++;
            tick_cnt += int'(a_tick);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL pause_frozen got=%0d bad cycles exp=0", bad); end
        checks++; if (tick_cnt != 20) begin failures++; $display("FAIL pause_ticks got=%0d exp=20", tick_cnt); end
        a_pause = 0;
        @(negedge clk);
        checks++; if ({a_sp, a_bcd} !== {1'b0, 8'h25}) begin failures++; $display("FAIL pause_release got=%b %h exp=0 25", a_sp, a_bcd); end
        repeat (3) @(negedge clk);
        checks++; if (a_bcd !== 8'h26) begin failures++; $display("FAIL pause_resume got=%h exp=26", a_bcd); end
    endtask

    // Test 6: async reset mid-count, then leading-digit display
    task automatic test_async_reset;
        a_load = 1; a_lv = 8'h37;
        @(negedge clk);
        a_load = 0;
        checks++; if (a_bcd !== 8'h37) begin failures++; $display("FAIL ar_load37 got=%h exp=37", a_bcd); end
        #2 a_rst_n = 0;
        #1;
        checks++; if ({a_bcd, a_tick, a_rco, a_lerr, a_sp} !== 12'h000) begin failures++; $display("FAIL ar_outputs got=%h %b%b%b%b", a_bcd, a_tick, a_rco, a_lerr, a_sp); end
        checks++; if (a_seg !== {7'b1000000, 7'b1000000}) begin failures++; $display("FAIL ar_seg got=%b", a_seg); end
        @(negedge clk);
        a_rst_n = 1; a_pause = 1; a_load = 1; a_lv = 8'h05;
        @(negedge clk);
        a_load = 0;
        @(negedge clk);
        checks++; if (a_seg[13:7] !== exp_seg(5)[13:7]) begin failures++; $display("FAIL seg_lead got=%b exp=%b", a_seg[13:7], exp_seg(5)[13:7]); end
        checks++; if (a_seg[6:0] !== 7'b0010010) begin failures++; $display("FAIL seg_ones got=%b exp=0010010", a_seg[6:0]); end
        a_pause = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_simultaneous();
        test_pause();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
